// File: rtl/bitty_pkg.sv
// Shared definitions for the instruction-memory stream loader: instruction
// word width and the loader FSM state encoding.
package bitty_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        D_HI   = 3'd3,
        D_LO   = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 16-bit
// words from address 0 upward, then pulses load_done.
//
//   state  | meaning
//   IDLE   | waiting for load_start
//   LEN_HI | accepting high byte of word count N
//   LEN_LO | accepting low byte of N; N==0 finishes at once
//   D_HI   | accepting high byte of a data word
//   D_LO   | accepting low byte; memory write is launched on this handshake
//   WRITE  | write strobe cycle, count/remaining bookkeeping
//   DONE   | one-cycle load_done pulse
module imem_stream_loader
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               load_done,
    output logic [15:0]        word_count,
    output logic               err_ovf
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INSTR_W-1:0]  wdata_q, wdata_d;
    logic                ovf_q, ovf_d;

    logic                hs;
    logic [15:0]         len_w;
    logic                room;

    assign hs    = in_valid && in_ready;
    // hi_q doubles as the length high byte while in LEN_LO
    assign len_w = {hi_q, in_data};
    assign room  = ({1'b0, count_q} < DEPTH_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            hi_q        <= '0;
            count_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            count_q     <= count_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        count_d     = count_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ovf_d       = ovf_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        load_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LEN_HI;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            LEN_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs) begin
                    hi_d    = in_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs) begin
                    remaining_d = len_w;
                    if (len_w == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        if ({1'b0, len_w} > DEPTH_L) ovf_d = 1'b1;
                        state_d = D_HI;
                    end
                end
            end
            D_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs) begin
                    hi_d    = in_data;
                    state_d = D_LO;
                end
            end
            D_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (hs) begin
                    state_d = WRITE;
                    // launched here so the registered strobe lines up with WRITE
                    if (room) begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = {hi_q, in_data};
                    end
                end
            end
            WRITE: begin
                busy        = 1'b1;
                if (room) count_d = count_q + 16'd1;
                remaining_d = remaining_q - 16'd1;
                state_d     = (remaining_q == 16'd1) ? DONE : D_HI;
            end
            DONE: begin
                load_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;
    assign err_ovf    = ovf_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Drives one byte stream into two loaders (DEPTH 256 and DEPTH 4) and checks
// writes and completion status against per-depth expectation queues.
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy [2];
    logic        we [2];
    logic [7:0]  addr [2];
    logic [15:0] wdata [2];
    logic        busy [2];
    logic        ld_done [2];
    logic [15:0] wc [2];
    logic        err [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] wq [2][$];
    logic [16:0] dq [2][$];
    logic [23:0] w_exp;
    logic [16:0] d_exp;

    always #5 clk = ~clk;

    imem_stream_loader #(.ADDR_W(8), .DEPTH(256)) u_big (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .busy(busy[0]), .load_done(ld_done[0]),
        .word_count(wc[0]), .err_ovf(err[0])
    );

    imem_stream_loader #(.ADDR_W(8), .DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .busy(busy[1]), .load_done(ld_done[1]),
        .word_count(wc[1]), .err_ovf(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write and every load_done is matched against the queues.
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                if (we[d]) begin
                    if (wq[d].size() == 0) begin
                        check($sformatf("unexpected_write_dut%0d", d), {8'h0, addr[d], wdata[d]}, 32'hFFFF_FFFF);
                    end else begin
                        w_exp = wq[d].pop_front();
                        check($sformatf("write_dut%0d", d), {8'h0, addr[d], wdata[d]}, {8'h0, w_exp});
                    end
                end
                if (ld_done[d]) begin
                    if (dq[d].size() == 0) begin
                        check($sformatf("unexpected_done_dut%0d", d), 32'd1, 32'd0);
                    end else begin
                        d_exp = dq[d].pop_front();
                        check($sformatf("done_wc_dut%0d", d), {16'h0, wc[d]}, {16'h0, d_exp[15:0]});
                        check($sformatf("done_err_dut%0d", d), {31'h0, err[d]}, {31'h0, d_exp[16]});
                        check($sformatf("done_busy_dut%0d", d), {31'h0, busy[d]}, 32'd0);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_rdy"},   {31'h0, rdy[d]},     32'd0);
            check({tag, "_we"},    {31'h0, we[d]},      32'd0);
            check({tag, "_addr"},  {24'h0, addr[d]},    32'd0);
            check({tag, "_wdata"}, {16'h0, wdata[d]},   32'd0);
            check({tag, "_busy"},  {31'h0, busy[d]},    32'd0);
            check({tag, "_done"},  {31'h0, ld_done[d]}, 32'd0);
            check({tag, "_wc"},    {16'h0, wc[d]},      32'd0);
            check({tag, "_err"},   {31'h0, err[d]},     32'd0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit ok;
        ok = 0;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (rdy[0]) begin
                check("ready_match", {31'h0, rdy[1]}, 32'd1);
                ok = 1;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic arm();
        @(posedge clk); #1;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] words[$], input int gap,
                            input bit mid_start, input bit start_in_done);
        int  n;
        int  lat;
        bit  seen;
        n = words.size();
        for (int d = 0; d < 2; d++) begin
            int depth = (d == 0) ? 256 : 4;
            int nw    = (n < depth) ? n : depth;
            for (int i = 0; i < nw; i++) wq[d].push_back({8'(i), words[i]});
            dq[d].push_back({(n > depth) ? 1'b1 : 1'b0, 16'(nw)});
        end
        arm();
        for (int d = 0; d < 2; d++) begin
            check("arm_busy", {31'h0, busy[d]}, 32'd1);
            check("arm_wc",   {16'h0, wc[d]},   32'd0);
            check("arm_err",  {31'h0, err[d]},  32'd0);
        end
        send_byte(8'(n >> 8), gap);
        send_byte(8'(n), gap);
        if (mid_start) begin
            load_start = 1'b1;
            @(posedge clk); #1;
            load_start = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], gap);
            send_byte(words[i][7:0], gap);
            check("we_after_lo_big",   {31'h0, we[0]}, 32'd1);
            check("we_after_lo_small", {31'h0, we[1]}, (i < 4) ? 32'd1 : 32'd0);
        end
        seen = 0;
        lat  = 0;
        for (int t = 1; t <= 200 && !seen; t++) begin
            @(negedge clk);
            if (ld_done[0]) begin
                seen = 1;
                lat  = t;
            end
        end
        check("done_seen", {31'h0, seen}, 32'd1);
        check("done_latency", lat, (n == 0) ? 32'd1 : 32'd2);
        check("done_both", {31'h0, ld_done[1]}, 32'd1);
        if (start_in_done) load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        if (start_in_done) begin
            repeat (2) @(posedge clk);
            #1;
            check("start_in_done_busy",  {31'h0, busy[0]}, 32'd0);
            check("start_in_done_ready", {31'h0, rdy[0]},  32'd0);
        end
    endtask

    initial begin
        logic [15:0] w[$];

        #1;
        check_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // basic two-word program
        w = '{16'h1234, 16'hABCD};
        run_load(w, 0, 0, 0);
        check("case1_wc_big", {16'h0, wc[0]}, 32'd2);

        // empty program
        w = {};
        run_load(w, 0, 0, 0);

        // six words: overflows the DEPTH=4 loader only
        w = {};
        for (int i = 0; i < 6; i++) w.push_back(16'($urandom));
        run_load(w, 0, 0, 0);
        check("ovf_err_small", {31'h0, err[1]}, 32'd1);
        check("ovf_wc_small",  {16'h0, wc[1]},  32'd4);
        check("ovf_err_big",   {31'h0, err[0]}, 32'd0);

        // basic program with random valid gaps
        w = '{16'h1234, 16'hABCD};
        run_load(w, 50, 0, 0);

        // reset after the first data byte
        arm();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h5A, 0);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b1;
        w = '{16'hC0DE, 16'hBEEF, 16'h0F0F};
        run_load(w, 20, 0, 0);

        // load_start while busy and in the DONE cycle, then back-to-back load
        w = {};
        for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
        run_load(w, 30, 1, 1);
        w = '{16'h1111, 16'h2222};
        run_load(w, 0, 0, 0);

        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(0, 9);
            w = {};
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            run_load(w, $urandom_range(0, 60), 0, 0);
        end

        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            check("writes_left", wq[d].size(), 32'd0);
            check("dones_left",  dq[d].size(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
